// File: rtl/nn_pkg.sv
// nn_pkg: constants, score vector type and FSM state shared by the network layers.
package nn_pkg;
    localparam int CLASS_NB   = 10;
    localparam int DATA_WIDTH = 16;
    typedef logic signed [DATA_WIDTH-1:0] score_vec_t [CLASS_NB];
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
endpackage

// File: rtl/argmax_classifier_if.sv
// argmax_classifier_if: score-vector input and classification result handshake.
interface argmax_classifier_if #(
    parameter int CLASS_NB = nn_pkg::CLASS_NB,
    parameter int WIDTH    = nn_pkg::DATA_WIDTH,
    parameter int IDX_W    = $clog2(CLASS_NB)
);
    logic signed [WIDTH-1:0] in_data [CLASS_NB];
    logic                    in_valid;
    logic                    in_ready;
    logic [IDX_W-1:0]        out_class;
    logic signed [WIDTH-1:0] out_score;
    logic [WIDTH-1:0]        out_margin;
    logic                    out_valid;
    logic                    out_ready;
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_class, out_score, out_margin, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_class, out_score, out_margin, out_valid);
endinterface

// File: rtl/argmax_classifier.sv
// argmax_classifier: captures a score vector, scans it one element per cycle and
// reports the winning class, its score and the margin over the runner-up.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int CLASS_NB = nn_pkg::CLASS_NB,
    parameter int WIDTH    = nn_pkg::DATA_WIDTH,
    parameter int IDX_W    = $clog2(CLASS_NB)
) (
    input logic                clk,
    input logic                reset,
    argmax_classifier_if.slave bus
);
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q, best_idx_q, best_idx_d, class_q;
    logic signed [WIDTH-1:0] buf_q [CLASS_NB];
    logic signed [WIDTH-1:0] best_q, best_d, second_q, second_d, x, score_q;
    logic signed [WIDTH:0]   diff;
    logic [WIDTH-1:0]        margin_d, margin_q;
    logic                    gt_best, valid_q;
    // Strict compare keeps the lower index on ties; the equal score becomes runner-up.
    always_comb begin
        x          = buf_q[idx_q];
        gt_best    = x > best_q;
        best_d     = gt_best ? x : best_q;
        best_idx_d = gt_best ? idx_q : best_idx_q;
        second_d   = gt_best ? best_q : (x > second_q ? x : second_q);
        diff       = {best_d[WIDTH-1], best_d} - {second_d[WIDTH-1], second_d};
        margin_d   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.in_valid) buf_q <= bus.in_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            second_q   <= '0;
            class_q    <= '0;
            score_q    <= '0;
            margin_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    best_q     <= bus.in_data[0];
                    best_idx_q <= '0;
                    second_q   <= MOST_NEG;
                    idx_q      <= IDX_W'(1);
                    state_q    <= SCAN;
                end
                SCAN: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    second_q   <= second_d;
                    idx_q      <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(CLASS_NB - 1)) begin
                        class_q <= best_idx_d;
                        score_q <= best_d;
                        margin_q <= margin_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: if (bus.out_ready) begin
                    valid_q <= 1'b0;
                    idx_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready   = (state_q == IDLE) & ~reset;
    assign bus.out_class  = class_q;
    assign bus.out_score  = score_q;
    assign bus.out_margin = margin_q;
    assign bus.out_valid  = valid_q;
endmodule
